alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
Reservation station and issue scheduler in front of the single-cycle integer ALU. It buffers up to DEPTH dispatched OP/OP-IMM instructions and captures missing source operands from the result broadcast bus. Each cycle it issues the oldest instruction whose operands are all ready to the ALU over a valid/ready handshake. It sits between dispatch/rename and the ALU in the execute stage.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 4, width of a physical/ROB source tag

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  pipeline flush; squashes all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  free entry available and no flush
disp_instr  in  decoded_instr  op, funct3, imm, rd, rs1_val, rs2_val
disp_rs1_tag  in  TAG_W  producer tag of rs1
disp_rs1_rdy  in  1  rs1_val already valid
disp_rs2_tag  in  TAG_W  producer tag of rs2
disp_rs2_rdy  in  1  rs2_val already valid; ignored for OP-IMM
wb_valid  in  1  result broadcast valid
wb_tag  in  TAG_W  broadcast tag
wb_val  in  32  broadcast value
iss_valid  out  1  issue to ALU
iss_ready  in  1  ALU accepts
iss_instr  out  decoded_instr  instruction with resolved operands
occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset is asynchronous. All entries become invalid. Outputs settle to: occupancy=0, iss_valid=0, disp_ready=1, iss_instr=0.
- Storage is a compacting queue. Slot 0 is the oldest entry. Valid entries are contiguous from slot 0.
- Per-entry state: valid, instr, rs1_rdy/tag, rs2_rdy/tag. OP-IMM entries force rs2_rdy=1 at dispatch.
- Dispatch fires when disp_valid && disp_ready. The entry is written at slot occupancy, or occupancy-1 if an issue fires in the same cycle (post-compaction).
- disp_ready = !flush && (occupancy < DEPTH). It is computed from registered state only; a slot freed by a same-cycle issue is not reused that cycle.
- Wakeup: for each valid entry with src_rdy=0 and wb_valid && wb_tag==src_tag, latch wb_val into the operand and set rdy at the edge.
- Dispatch bypass: a dispatched operand with rdy=0 whose tag matches the same-cycle broadcast is written as ready with wb_val.
- Select: iss_valid is set if any entry has both operands ready. The lowest ready slot is presented on iss_instr. The output is combinational from registers, with no same-cycle wakeup→issue bypass. Minimum latency is dispatch at t, issue at t+1; wakeup at t, issue at t+1.
- Issue fires when iss_valid && iss_ready. The issued slot is removed and younger slots shift down one at the edge. Wakeup applies to shifting entries in the same edge.
- If iss_ready=0, iss_instr holds the current selection. A newly readied older entry may overtake the held one, because selection is re-evaluated every cycle and the ALU is combinational.
- Flush: iss_valid=0 and disp_ready=0 while flush=1. All entries are invalidated at the edge, and dispatch/wakeup in that cycle are discarded.
- Full, with issue and dispatch in the same cycle: the dispatch is refused, since disp_ready=0.
- Empty, with dispatch of a fully-ready entry: iss_valid=0 this cycle and 1 next cycle.
- Tag comparison covers all TAG_W bits. No tag is reserved.

Optional Feature:
ALU_SCHED_PERF_EN
- With the macro defined: adds output ports perf_issued (32) and perf_stall (32).
  - perf_issued increments on each issue.
  - perf_stall increments on cycles with occupancy>0 && !iss_valid.
  - Both counters reset to 0 on rst, are not cleared by flush, and wrap modulo 2^32.
- Without the macro: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package: decoded_instr (already used by the ALU), rs_entry_t struct {valid, instr, rs1_rdy, rs1_tag, rs2_rdy, rs2_tag}, tag_t typedef of TAG_W.
- Sub-module alu_sched_select: a combinational priority picker returning the lowest ready slot index and a found flag.

Test Plan:
- Ready dispatch: dispatch ADD rs1=5, rs2=7, both rdy, iss_ready=1 → iss_valid rises 1 cycle later with rs1_val=5, rs2_val=7; occupancy goes 1→0.
- Wakeup: dispatch with rs1 not ready (tag 3), then wb_valid, tag 3, val 0x10 two cycles later → issue the cycle after broadcast with rs1_val=0x10.
- Ordering: dispatch A (blocked on tag 2) then B (ready) → B issues first. Broadcast tag 2 → A issues next. Occupancy returns to 0.
- Full: DEPTH=4, fill with 4 blocked entries → disp_ready=0. Issue one and dispatch in the same cycle → dispatch refused. disp_ready=1 the next cycle.
- Bypass plus flush: dispatch with rs2 tag 9 while wb_tag=9, val 0xAB → entry ready and issues next cycle with rs2_val=0xAB. Fill 3 entries and assert flush → iss_valid=0 during flush, occupancy=0 after the edge.
- Backpressure: hold iss_ready=0 for 3 cycles with one ready entry → iss_valid stays 1 and iss_instr is stable. Release → the entry is removed.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU reservation station: decoded instruction, source tag,
// and the per-slot entry record.
package alu_sched_pkg;

  localparam int TAG_W_P = 4;

  typedef logic [TAG_W_P-1:0] tag_t;

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } decoded_instr;

  typedef struct packed {
    logic         valid;
    decoded_instr instr;
    logic         rs1_rdy;
    tag_t         rs1_tag;
    logic         rs2_rdy;
    tag_t         rs2_tag;
  } rs_entry_t;

  // A waiting operand captures the broadcast when the full tag matches.
  function automatic logic tag_hit(input logic wb_valid, input tag_t wb_tag,
                                   input logic src_rdy, input tag_t src_tag);
    return wb_valid && !src_rdy && (wb_tag == src_tag);
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Dispatch, result-broadcast and issue signals between rename, the scheduler
// and the ALU; master is the pipeline side, slave is the scheduler.
interface alu_sched_if #(
  parameter int TAG_W = alu_sched_pkg::TAG_W_P
);
  import alu_sched_pkg::*;

  logic               flush;
  logic               disp_valid;
  logic               disp_ready;
  decoded_instr       disp_instr;
  logic [TAG_W-1:0]   disp_rs1_tag;
  logic               disp_rs1_rdy;
  logic [TAG_W-1:0]   disp_rs2_tag;
  logic               disp_rs2_rdy;
  logic               wb_valid;
  logic [TAG_W-1:0]   wb_tag;
  logic [31:0]        wb_val;
  logic               iss_valid;
  logic               iss_ready;
  decoded_instr       iss_instr;

  modport master (
    output flush, disp_valid, disp_instr, disp_rs1_tag, disp_rs1_rdy,
           disp_rs2_tag, disp_rs2_rdy, wb_valid, wb_tag, wb_val, iss_ready,
    input  disp_ready, iss_valid, iss_instr
  );

  modport slave (
    input  flush, disp_valid, disp_instr, disp_rs1_tag, disp_rs1_rdy,
           disp_rs2_tag, disp_rs2_rdy, wb_valid, wb_tag, wb_val, iss_ready,
    output disp_ready, iss_valid, iss_instr
  );

endinterface

// File: rtl/alu_sched_select.sv
// Priority picker: reports the lowest-numbered ready slot and whether any slot
// is ready at all. Slot 0 is the oldest, so this is oldest-first selection.
module alu_sched_select #(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the youngest slot down so the oldest ready slot wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      found_o = found_o | ready_i[i];
      idx_o   = ready_i[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Reservation station / oldest-ready issue scheduler in front of the ALU.
// Optional event counters are compiled in with ALU_SCHED_PERF_EN.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = TAG_W_P,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  alu_sched_if.slave       bus,
  output logic [OCC_W-1:0] occupancy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_d [DEPTH];
  rs_entry_t        woke_s    [DEPTH];
  rs_entry_t        new_s;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] wr_idx_s;

  logic [DEPTH-1:0] rdy_s;
  logic             sel_found_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             iss_fire_s;
  logic             disp_fire_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             is_imm_s;

  logic [TAG_W-1:0] wb_tag_s;
  logic [TAG_W-1:0] rs1_tag_s;
  logic [TAG_W-1:0] rs2_tag_s;

  assign wb_tag_s  = bus.wb_tag;
  assign rs1_tag_s = bus.disp_rs1_tag;
  assign rs2_tag_s = bus.disp_rs2_tag;

  // Issue candidates come from registered state only; no wakeup bypass.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_s[i] = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
    end
  end

  alu_sched_select #(.DEPTH(DEPTH)) u_select (
    .ready_i (rdy_s),
    .found_o (sel_found_s),
    .idx_o   (sel_idx_s)
  );

  assign bus.iss_valid  = sel_found_s && !bus.flush;
  assign bus.iss_instr  = sel_found_s ? entries_q[sel_idx_s].instr : '0;
  assign bus.disp_ready = !bus.flush && (occ_q < OCC_W'(DEPTH));
  assign iss_fire_s     = bus.iss_valid && bus.iss_ready;
  assign disp_fire_s    = bus.disp_valid && bus.disp_ready;
  assign occupancy      = occ_q;

  // Resident entries capture a matching broadcast before any compaction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic hit1;
      logic hit2;
      hit1 = entries_q[i].valid &&
             tag_hit(bus.wb_valid, wb_tag_s, entries_q[i].rs1_rdy, entries_q[i].rs1_tag);
      hit2 = entries_q[i].valid &&
             tag_hit(bus.wb_valid, wb_tag_s, entries_q[i].rs2_rdy, entries_q[i].rs2_tag);
      woke_s[i]               = entries_q[i];
      woke_s[i].rs1_rdy       = entries_q[i].rs1_rdy | hit1;
      woke_s[i].instr.rs1_val = hit1 ? bus.wb_val : entries_q[i].instr.rs1_val;
      woke_s[i].rs2_rdy       = entries_q[i].rs2_rdy | hit2;
      woke_s[i].instr.rs2_val = hit2 ? bus.wb_val : entries_q[i].instr.rs2_val;
    end
  end

  // Incoming entry, with same-cycle broadcast bypass; OP-IMM has no rs2.
  always_comb begin
    is_imm_s            = (bus.disp_instr.op == OPC_OP_IMM);
    byp1_s              = tag_hit(bus.wb_valid, wb_tag_s, bus.disp_rs1_rdy, rs1_tag_s);
    byp2_s              = !is_imm_s &&
                          tag_hit(bus.wb_valid, wb_tag_s, bus.disp_rs2_rdy, rs2_tag_s);
    new_s               = '0;
    new_s.valid         = 1'b1;
    new_s.instr         = bus.disp_instr;
    new_s.rs1_tag       = rs1_tag_s;
    new_s.rs2_tag       = rs2_tag_s;
    new_s.rs1_rdy       = bus.disp_rs1_rdy | byp1_s;
    new_s.instr.rs1_val = byp1_s ? bus.wb_val : bus.disp_instr.rs1_val;
    new_s.rs2_rdy       = bus.disp_rs2_rdy | is_imm_s | byp2_s;
    new_s.instr.rs2_val = byp2_s ? bus.wb_val : bus.disp_instr.rs2_val;
  end

  // Queue update: flush, then compaction over the issued slot, then append.
  always_comb begin
    occ_d    = occ_q;
    wr_idx_s = occ_q;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = woke_s[i];
    end
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      occ_d = '0;
    end else begin
      if (iss_fire_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entries_d[i] = (IDX_W'(i) >= sel_idx_s) ? woke_s[i+1] : woke_s[i];
        end
        entries_d[DEPTH-1] = '0;
        wr_idx_s           = occ_q - OCC_W'(1);
      end else begin
        wr_idx_s = occ_q;
      end
      // wr_idx_s is always below DEPTH here because disp_ready requires a free slot.
      if (disp_fire_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          entries_d[i] = (OCC_W'(i) == wr_idx_s) ? new_s : entries_d[i];
        end
      end else begin
        wr_idx_s = wr_idx_s;
      end
      occ_d = occ_q + OCC_W'(disp_fire_s) - OCC_W'(iss_fire_s);
    end
  end

  // Entry storage and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;
  logic        stall_s;

  assign stall_s = (occ_q != '0) && !bus.iss_valid;

  // Event counters survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      perf_issued_q <= perf_issued_q + {31'd0, iss_fire_s};
      perf_stall_q  <= perf_stall_q + {31'd0, stall_s};
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed scoreboard bench for alu_sched: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever an issue handshake occurs.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] occupancy;
`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  alu_sched_if #(.TAG_W(TAG_W_P)) bus ();

  alu_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W_P)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occupancy)
`ifdef ALU_SCHED_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  decoded_instr exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic decoded_instr mk(input opcode_t op, input logic [4:0] rd,
                                      input logic [31:0] a, input logic [31:0] b);
    decoded_instr d;
    d         = '0;
    d.op      = op;
    d.funct3  = 3'b000;
    d.imm     = (op == OPC_OP_IMM) ? 32'd5 : 32'd0;
    d.rd      = rd;
    d.rs1_val = a;
    d.rs2_val = b;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic disp(input decoded_instr d, input logic r1, input tag_t t1,
                      input logic r2, input tag_t t2);
    bus.disp_valid   = 1'b1;
    bus.disp_instr   = d;
    bus.disp_rs1_rdy = r1;
    bus.disp_rs1_tag = t1;
    bus.disp_rs2_rdy = r2;
    bus.disp_rs2_tag = t2;
  endtask

  task automatic wb(input tag_t t, input logic [31:0] v);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = t;
    bus.wb_val   = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.disp_valid = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  // Scoreboard monitor: every issue handshake must match the next expected instr.
  always @(negedge clk) begin
    decoded_instr e;
    if (!rst && bus.iss_valid && bus.iss_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got rd=%0d rs1=%h rs2=%h, expected no issue",
                 bus.iss_instr.rd, bus.iss_instr.rs1_val, bus.iss_instr.rs2_val);
      end else begin
        e = exp_q.pop_front();
        if (bus.iss_instr !== e) begin
          n_err++;
          $display("FAIL issue_instr: got rd=%0d rs1=%h rs2=%h, expected rd=%0d rs1=%h rs2=%h",
                   bus.iss_instr.rd, bus.iss_instr.rs1_val, bus.iss_instr.rs2_val,
                   e.rd, e.rs1_val, e.rs2_val);
        end
      end
    end
  end

  initial begin
    decoded_instr e;
    decoded_instr a;
    decoded_instr b;
    decoded_instr f [4];

    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.disp_valid   = 1'b0;
    bus.disp_instr   = '0;
    bus.disp_rs1_tag = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs2_tag = '0;
    bus.disp_rs2_rdy = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_tag       = '0;
    bus.wb_val       = 32'd0;
    bus.iss_ready    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("rst_iss_instr_zero", 32'(bus.iss_instr == '0), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ready dispatch: issue one cycle after dispatch.
    bus.iss_ready = 1'b1;
    e = mk(OPC_OP, 5'd1, 32'd5, 32'd7);
    exp_q.push_back(e);
    disp(e, 1'b1, 4'd0, 1'b1, 4'd0);
    @(negedge clk); chk("s1_empty_no_issue", 32'(bus.iss_valid), 32'd0); step();
    @(negedge clk); chk("s1_iss_valid", 32'(bus.iss_valid), 32'd1);
                    chk("s1_occ1", 32'(occupancy), 32'd1); step();
    @(negedge clk); chk("s1_occ0", 32'(occupancy), 32'd0); step();

    // Wakeup: broadcast two cycles after dispatch.
    e = mk(OPC_OP, 5'd2, 32'hDEAD, 32'd1);
    disp(e, 1'b0, 4'd3, 1'b1, 4'd0);
    e.rs1_val = 32'h10;
    exp_q.push_back(e);
    @(negedge clk); step();
    @(negedge clk); chk("s2_blocked", 32'(bus.iss_valid), 32'd0); step();
    wb(4'd3, 32'h10);
    @(negedge clk); chk("s2_no_wb_bypass", 32'(bus.iss_valid), 32'd0); step();
    @(negedge clk); chk("s2_woken", 32'(bus.iss_valid), 32'd1); step();
    @(negedge clk); chk("s2_occ0", 32'(occupancy), 32'd0); step();

    // Ordering: younger ready entry overtakes older blocked one.
    a = mk(OPC_OP, 5'd3, 32'd0, 32'd3);
    disp(a, 1'b0, 4'd2, 1'b1, 4'd0);
    a.rs1_val = 32'h22;
    @(negedge clk); step();
    b = mk(OPC_OP, 5'd4, 32'd8, 32'd9);
    disp(b, 1'b1, 4'd0, 1'b1, 4'd0);
    exp_q.push_back(b);
    exp_q.push_back(a);
    @(negedge clk); step();
    @(negedge clk); chk("s3_occ2", 32'(occupancy), 32'd2);
                    chk("s3_b_first", 32'(bus.iss_instr.rd), 32'd4); step();
    wb(4'd2, 32'h22);
    @(negedge clk); chk("s3_a_blocked", 32'(bus.iss_valid), 32'd0); step();
    @(negedge clk); chk("s3_a_issue", 32'(bus.iss_valid), 32'd1); step();
    @(negedge clk); chk("s3_occ0", 32'(occupancy), 32'd0); step();

    // Full: four blocked entries, then issue+dispatch in the same cycle.
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f[k] = mk(OPC_OP, 5'(5 + k), 32'd0, 32'(5 + k));
      disp(f[k], 1'b0, 4'(5 + k), 1'b1, 4'd0);
      f[k].rs1_val = 32'(8'h11 * (5 + k));
      @(negedge clk); step();
    end
    wb(4'd6, 32'h66);
    @(negedge clk); chk("s4_full_ready", 32'(bus.disp_ready), 32'd0);
                    chk("s4_occ4", 32'(occupancy), 32'd4); step();
    bus.iss_ready = 1'b1;
    exp_q.push_back(f[1]);
    disp(mk(OPC_OP, 5'd9, 32'd1, 32'd2), 1'b1, 4'd0, 1'b1, 4'd0);
    @(negedge clk); chk("s4_refused", 32'(bus.disp_ready), 32'd0);
                    chk("s4_iss", 32'(bus.iss_valid), 32'd1); step();
    @(negedge clk); chk("s4_ready_again", 32'(bus.disp_ready), 32'd1);
                    chk("s4_occ3", 32'(occupancy), 32'd3); step();
    exp_q.push_back(f[0]);
    exp_q.push_back(f[2]);
    exp_q.push_back(f[3]);
    wb(4'd5, 32'h55); @(negedge clk); step();
    wb(4'd7, 32'h77); @(negedge clk); step();
    wb(4'd8, 32'h88); @(negedge clk); step();
    @(negedge clk); step();
    @(negedge clk); chk("s4_occ0", 32'(occupancy), 32'd0); step();

    // Dispatch bypass on rs2, and OP-IMM ignoring rs2 readiness.
    e = mk(OPC_OP, 5'd10, 32'd1, 32'd0);
    disp(e, 1'b1, 4'd0, 1'b0, 4'd9);
    wb(4'd9, 32'hAB);
    e.rs2_val = 32'hAB;
    exp_q.push_back(e);
    @(negedge clk); step();
    @(negedge clk); chk("s5_bypass_issue", 32'(bus.iss_valid), 32'd1); step();
    e = mk(OPC_OP_IMM, 5'd11, 32'h30, 32'd0);
    disp(e, 1'b1, 4'd0, 1'b0, 4'd15);
    exp_q.push_back(e);
    @(negedge clk); step();
    @(negedge clk); chk("s5_opimm_issue", 32'(bus.iss_valid), 32'd1); step();

    // Flush with three resident entries plus a concurrent dispatch and broadcast.
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(mk(OPC_OP, 5'(12 + k), 32'(k), 32'(k)), 1'b1, 4'd0, 1'b1, 4'd0);
      @(negedge clk); step();
    end
    bus.flush = 1'b1;
    disp(mk(OPC_OP, 5'd20, 32'd3, 32'd4), 1'b1, 4'd0, 1'b1, 4'd0);
    wb(4'd1, 32'd0);
    @(negedge clk); chk("s5_pre_flush_occ3", 32'(occupancy), 32'd3);
                    chk("s5_flush_iss_valid", 32'(bus.iss_valid), 32'd0);
                    chk("s5_flush_disp_ready", 32'(bus.disp_ready), 32'd0); step();
    bus.iss_ready = 1'b1;
    @(negedge clk); chk("s5_post_flush_occ", 32'(occupancy), 32'd0);
                    chk("s5_post_flush_iss", 32'(bus.iss_valid), 32'd0); step();

    // Backpressure: held selection stays stable, then drains on release.
    bus.iss_ready = 1'b0;
    e = mk(OPC_OP, 5'd15, 32'h100, 32'h200);
    disp(e, 1'b1, 4'd0, 1'b1, 4'd0);
    @(negedge clk); step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("s6_hold_valid", 32'(bus.iss_valid), 32'd1);
                      chk("s6_hold_instr", 32'(bus.iss_instr === e), 32'd1); step();
    end
    bus.iss_ready = 1'b1;
    exp_q.push_back(e);
    @(negedge clk); step();
    @(negedge clk); chk("s6_occ0", 32'(occupancy), 32'd0);
                    chk("s6_idle", 32'(bus.iss_valid), 32'd0); step();

    repeat (3) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
